mem_io_responder: RTL and testbench

Memory-side responder for the CPU's byte-wide memory bus. Serves RAM reads and writes from a 128 KB on-chip array, decodes the I/O window at 0x30000 and above, buffers UART transmit bytes in a FIFO, supplies UART receive bytes, and provides the cycle counter. It back-pressures the CPU through `io_buffer_full`. It sits between the CPU top and the UART/RAM shell, as the responding end of the `mem_a`/`mem_dout`/`mem_din`/`mem_wr` protocol.

---
 rtl/memio_pkg.sv | 20 ++
 rtl/memio_tx_fifo.sv | 53 +++++
 rtl/mem_io_responder.sv | 129 ++++++++++++
 tb/tb_mem_io_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memio_pkg.sv
// memio_pkg: address constants and the I/O window classifier shared by the
// mem_io_responder top and its helpers.
package memio_pkg;

  localparam logic [17:0] IO_RX_TX_ADDR    = 18'h30000;
  localparam logic [17:0] IO_CLK_STOP_ADDR = 18'h30004;

  typedef enum logic [1:0] {RAM, IO_UART, IO_CNT, IO_NONE} decode_e;

  // Only bits 17:0 of the CPU address are meaningful on this bus.
  function automatic decode_e memio_decode(input logic [17:0] a);
    decode_e d;
    if (a[17:16] != 2'b11)                      d = RAM;
    else if (a == IO_RX_TX_ADDR)                d = IO_UART;
    else if (a[17:2] == IO_CLK_STOP_ADDR[17:2]) d = IO_CNT;
    else                                        d = IO_NONE;
    return d;
  endfunction

endpackage

// File: rtl/memio_tx_fifo.sv
// memio_tx_fifo: byte FIFO for UART transmit. Pointers carry one extra MSB so
// full and empty are told apart without a separate count register.
module memio_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign head  = mem_q[rptr_q[AW-1:0]];

  // Pop only real data; a push into a full FIFO lands only when a pop frees a slot.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    wptr_d    = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d    = rptr_q + {{AW{1'b0}}, do_pop};
    count_nxt = wptr_d - rptr_d;
  end

  // Pointer state; reset empties the FIFO immediately.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Byte storage, contents need no reset.
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: responding end of the CPU byte bus. RAM, UART TX/RX window,
// stop flag and (with MEMIO_CYCLE_COUNTER_EN defined) a snapshotted cycle counter.
import memio_pkg::*;

module mem_io_responder #(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);
  localparam int            CW       = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_THR = CW'(TX_DEPTH - FULL_MARGIN);

  logic [17:0]   addr;
  decode_e       dec;
  logic          is_stop_wr, fifo_push, fifo_full, fifo_empty;
  logic [7:0]    fifo_wdata, cnt_byte;
  logic [CW-1:0] fifo_count, fifo_count_nxt;
  logic [7:0]    ram_q [2**RAM_ADDR_W];
  logic [7:0]    mem_din_q, mem_din_d;
  logic          stop_q, stop_d, io_full_q, io_full_d;
  logic          unused_ok;

  assign addr       = mem_a[17:0];
  assign dec        = memio_decode(addr);
  assign rx_ready   = !mem_wr && (dec == IO_UART) && rx_valid;
  assign is_stop_wr = mem_wr && (addr == IO_CLK_STOP_ADDR);
  // The stop write always enqueues a 0x00 marker; plain zero data is filtered.
  assign fifo_push  = is_stop_wr || (mem_wr && (dec == IO_UART) && (mem_dout != 8'h00));
  assign fifo_wdata = is_stop_wr ? 8'h00 : mem_dout;

  memio_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt)
  );

  assign tx_valid       = !fifo_empty;
  assign mem_din        = mem_din_q;
  assign program_stop   = stop_q;
  assign io_buffer_full = io_full_q;
  assign unused_ok      = ^{mem_a[31:18], fifo_full, fifo_count};

`ifdef MEMIO_CYCLE_COUNTER_EN
  logic [31:0] cnt_q, cnt_d, snap_q, snap_d;

  // Reading the low byte captures the live count so the upper bytes stay coherent.
  always_comb begin
    cnt_d    = cnt_q + 32'd1;
    snap_d   = snap_q;
    if (!mem_wr && (addr == IO_CLK_STOP_ADDR)) snap_d = cnt_q;
    cnt_byte = snap_d[7:0];
    case (addr[1:0])
      2'd1:    cnt_byte = snap_d[15:8];
      2'd2:    cnt_byte = snap_d[23:16];
      2'd3:    cnt_byte = snap_d[31:24];
      default: cnt_byte = snap_d[7:0];
    endcase
  end

  // Free-running counter and its snapshot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end
`else
  assign cnt_byte = 8'h00;
`endif

  // Read mux into the registered data return, sticky stop, near-full flag.
  always_comb begin
    mem_din_d = mem_din_q;
    if (!mem_wr) begin
      case (dec)
        RAM:     mem_din_d = ram_q[mem_a[RAM_ADDR_W-1:0]];
        IO_UART: mem_din_d = rx_valid ? rx_data : 8'h00;
        IO_CNT:  mem_din_d = cnt_byte;
        default: mem_din_d = 8'h00;
      endcase
    end
    stop_d    = stop_q | is_stop_wr;
    io_full_d = (fifo_count_nxt >= FULL_THR);
  end

  // Output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= '0;
      stop_q    <= 1'b0;
      io_full_q <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      stop_q    <= stop_d;
      io_full_q <= io_full_d;
    end
  end

  // RAM array; survives reset.
  always_ff @(posedge clk_in) begin
    if (mem_wr && (dec == RAM)) ram_q[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed stimulus, queue-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din, tx_data, rx_data;
  logic        mem_wr, io_buffer_full, tx_valid, tx_ready, rx_valid, rx_ready, program_stop;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_stop(program_stop)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state
  logic [7:0] q_m[$];
  logic [7:0] dutlog[$];
  logic [7:0] ram_m [int unsigned];
  bit         stop_m, din_chk;
  logic [7:0] din_m;
`ifdef MEMIO_CYCLE_COUNTER_EN
  int unsigned cnt_m, snap_m;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q_m.delete();
    stop_m  = 1'b0;
    din_m   = 8'h00;
    din_chk = 1'b1;
`ifdef MEMIO_CYCLE_COUNTER_EN
    cnt_m  = 0;
    snap_m = 0;
`endif
  endtask

  task automatic model_step();
    logic [17:0] a;
    int unsigned k;
    bit io, pop, acc;
    int sz;
    logic [7:0] pd;
    a   = mem_a[17:0];
    k   = {15'd0, a[16:0]};
    io  = (a[17:16] == 2'b11);
    sz  = q_m.size();
    pop = (sz != 0) && tx_ready;
    acc = 1'b0;
    pd  = 8'h00;
    if (mem_wr) begin
      din_chk = 1'b0;
      if (!io) ram_m[k] = mem_dout;
      else if (a == 18'h30000) begin
        if (mem_dout != 8'h00) begin acc = 1'b1; pd = mem_dout; end
      end else if (a == 18'h30004) begin
        acc = 1'b1; pd = 8'h00; stop_m = 1'b1;
      end
    end else begin
      din_chk = 1'b1;
      if (!io) begin
        din_chk = ram_m.exists(k);
        if (din_chk) din_m = ram_m[k];
      end else if (a == 18'h30000) begin
        din_m = rx_valid ? rx_data : 8'h00;
      end else if (a >= 18'h30004 && a <= 18'h30007) begin
`ifdef MEMIO_CYCLE_COUNTER_EN
        if (a == 18'h30004) snap_m = cnt_m;
        din_m = 8'((snap_m >> (8 * (a - 18'h30004))) & 32'hFF);
`else
        din_m = 8'h00;
`endif
      end else begin
        din_m = 8'h00;
      end
    end
    if (pop) void'(q_m.pop_front());
    if (acc && (sz < 16 || pop)) q_m.push_back(pd);
`ifdef MEMIO_CYCLE_COUNTER_EN
    cnt_m++;
`endif
  endtask

  task automatic check_outputs();
    chk("tx_valid", 32'(tx_valid), 32'(q_m.size() != 0));
    if (q_m.size() != 0) chk("tx_data", 32'(tx_data), 32'(q_m[0]));
    chk("io_buffer_full", 32'(io_buffer_full), 32'((16 - q_m.size()) <= 2));
    chk("program_stop", 32'(program_stop), 32'(stop_m));
    if (din_chk) chk("mem_din", 32'(mem_din), 32'(din_m));
  endtask

  // Per-cycle compare: combinational rx_ready and the TX handshake before the
  // edge, registered outputs just after it.
  always @(posedge clk_in) begin
    if (rst_in) begin
      chk("rx_ready", 32'(rx_ready),
          32'(!mem_wr && (mem_a[17:0] == 18'h30000) && rx_valid));
      if (tx_valid && tx_ready) dutlog.push_back(tx_data);
      model_step();
    end
    #1;
    check_outputs();
  end

  always @(negedge rst_in) model_reset();

  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    @(negedge clk_in);
    mem_wr = wr; mem_a = a; mem_dout = d;
  endtask

  task automatic idle();
    bus(1'b0, 32'h30008, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int g;
    mem_wr = 1'b0; mem_a = 32'h30008; mem_dout = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (2) @(negedge clk_in);
    chk("reset mem_din", 32'(mem_din), 32'h00);
    chk("reset tx_valid", 32'(tx_valid), 32'h0);
    chk("reset io_buffer_full", 32'(io_buffer_full), 32'h0);
    chk("reset program_stop", 32'(program_stop), 32'h0);
    rst_in = 1'b1;

    // RAM round trip and address-range edges
    bus(1'b1, 32'h00123, 8'hA5);
    bus(1'b0, 32'h00123, 8'h00);
    idle();
    chk("ram roundtrip", 32'(mem_din), 32'hA5);
    bus(1'b1, 32'h1FFFF, 8'h3C);
    bus(1'b1, 32'h00000, 8'h5A);
    bus(1'b1, 32'h2FFFF, 8'hC3);
    bus(1'b1, 32'h30008, 8'h99);
    bus(1'b0, 32'h1FFFF, 8'h00);
    bus(1'b0, 32'h00000, 8'h00);
    chk("ram top", 32'(mem_din), 32'h3C);
    bus(1'b0, 32'h2FFFF, 8'h00);
    chk("ram bottom", 32'(mem_din), 32'h5A);
    idle();
    chk("ram below io", 32'(mem_din), 32'hC3);

    // UART output filters zero bytes
    tx_ready = 1'b1;
    n0 = dutlog.size();
    bus(1'b1, 32'h30000, 8'h41);
    bus(1'b1, 32'h30000, 8'h00);
    bus(1'b1, 32'h30000, 8'h42);
    repeat (3) idle();
    chk("uart count", 32'(dutlog.size() - n0), 32'd2);
    if (dutlog.size() - n0 == 2) begin
      chk("uart byte0", 32'(dutlog[n0]), 32'h41);
      chk("uart byte1", 32'(dutlog[n0+1]), 32'h42);
    end

    // Back-pressure and overflow drop
    tx_ready = 1'b0;
    idle();
    n0 = dutlog.size();
    for (int i = 1; i <= 13; i++) bus(1'b1, 32'h30000, 8'(i));
    idle();
    chk("bp after 13", 32'(io_buffer_full), 32'h0);
    bus(1'b1, 32'h30000, 8'd14);
    idle();
    chk("bp after 14", 32'(io_buffer_full), 32'h1);
    for (int i = 15; i <= 17; i++) bus(1'b1, 32'h30000, 8'(i));
    idle();
    chk("bp full", 32'(io_buffer_full), 32'h1);
    tx_ready = 1'b1;
    repeat (20) idle();
    chk("bp drained", 32'(dutlog.size() - n0), 32'd16);
    if (dutlog.size() - n0 == 16)
      for (int i = 0; i < 16; i++) chk("bp byte", 32'(dutlog[n0+i]), 32'(i + 1));
    chk("bp empty", 32'(tx_valid), 32'h0);

    // Counter snapshot
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
`ifdef MEMIO_CYCLE_COUNTER_EN
    g = 0;
    while (cnt_m != 32'hFF && g < 1000) begin
      @(negedge clk_in);
      g++;
    end
    chk("cnt wait bound", 32'(g < 1000), 32'h1);
    mem_wr = 1'b0; mem_a = 32'h30004;
    bus(1'b0, 32'h30005, 8'h00);
    chk("cnt byte0", 32'(mem_din), 32'hFF);
    bus(1'b0, 32'h30006, 8'h00);
    chk("cnt byte1", 32'(mem_din), 32'h00);
    bus(1'b0, 32'h30007, 8'h00);
    chk("cnt byte2", 32'(mem_din), 32'h00);
    idle();
    chk("cnt byte3", 32'(mem_din), 32'h00);
`else
    g = 0;
    bus(1'b1, 32'h00010, 8'h77);
    bus(1'b0, 32'h00010, 8'h00);
    bus(1'b0, 32'h30004, 8'h00);
    chk("pre cnt ram", 32'(mem_din), 32'h77);
    bus(1'b0, 32'h30005, 8'h00);
    chk("cnt off byte0", 32'(mem_din), 32'h00);
    bus(1'b0, 32'h30007, 8'h00);
    chk("cnt off byte1", 32'(mem_din), 32'h00);
    idle();
    chk("cnt off byte3", 32'(mem_din), 32'h00 + 32'(g));
`endif

    // RX path
    @(negedge clk_in);
    rx_valid = 1'b1; rx_data = 8'h37; mem_wr = 1'b0; mem_a = 32'h30000;
    #1 chk("rx_ready high", 32'(rx_ready), 32'h1);
    idle();
    #1 chk("rx_ready low", 32'(rx_ready), 32'h0);
    chk("rx data", 32'(mem_din), 32'h37);
    @(negedge clk_in);
    rx_valid = 1'b0; mem_a = 32'h30000;
    #1 chk("rx_ready idle", 32'(rx_ready), 32'h0);
    idle();
    chk("rx empty data", 32'(mem_din), 32'h00);

    // Stop marker, then reset mid-drain
    tx_ready = 1'b0;
    n0 = dutlog.size();
    bus(1'b1, 32'h30005, 8'h12);
    idle();
    chk("stop ignores 30005", 32'(program_stop), 32'h0);
    bus(1'b1, 32'h30000, 8'h61);
    bus(1'b1, 32'h30004, 8'h77);
    bus(1'b1, 32'h30000, 8'h62);
    bus(1'b1, 32'h30000, 8'h63);
    idle();
    chk("stop set", 32'(program_stop), 32'h1);
    chk("stop head", 32'(tx_data), 32'h61);
    tx_ready = 1'b1;
    bus(1'b0, 32'h00123, 8'h00);
    idle();
    chk("stop tx count", 32'(dutlog.size() - n0), 32'd2);
    if (dutlog.size() - n0 == 2) begin
      chk("stop tx byte0", 32'(dutlog[n0]), 32'h61);
      chk("stop tx marker", 32'(dutlog[n0+1]), 32'h00);
    end
    chk("pre-reset mem_din", 32'(mem_din), 32'hA5);
    chk("pre-reset tx_valid", 32'(tx_valid), 32'h1);
    #2 rst_in = 1'b0;
    #1;
    chk("async tx_valid", 32'(tx_valid), 32'h0);
    chk("async io_buffer_full", 32'(io_buffer_full), 32'h0);
    chk("async program_stop", 32'(program_stop), 32'h0);
    chk("async mem_din", 32'(mem_din), 32'h00);
    @(negedge clk_in);
    rst_in = 1'b1;
    bus(1'b0, 32'h00123, 8'h00);
    idle();
    chk("ram kept over reset", 32'(mem_din), 32'hA5);
    chk("fifo empty after reset", 32'(tx_valid), 32'h0);

    repeat (2) @(negedge clk_in);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
